nway_trace_request_tracker: RTL

Consumes trace-repository entries (trace index plus data memory address) and drives prefetch requests into the n-way cache. Holds a small pool of tracker slots, each walking MAKE_REQUEST → WAIT_FOR_PROCESSING → REQUEST_RETIRED. Reports every retired entry back to the trace repository so the entry can be released from the active set. Sits directly downstream of the trace repository and upstream of the cache request port.

---
 rtl/nway_trace_request_tracker_if.sv | 43 ++++
 rtl/nway_trace_request_tracker.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/nway_trace_request_tracker_if.sv
// Handshake bundle between trace repository, tracker and cache.
// slave = tracker side, master = environment side.
interface nway_trace_request_tracker_if #(
  parameter int TRACKER_SLOTS = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int INDEX_WIDTH   = 4
);
  localparam int SW =
    (TRACKER_SLOTS > 1) ? $clog2(TRACKER_SLOTS) : 1;
  localparam int OW = $clog2(TRACKER_SLOTS + 1);

  logic                   in_valid;
  logic                   in_ready;
  logic [INDEX_WIDTH-1:0] in_trace_index;
  logic [ADDR_WIDTH-1:0]  in_mem_addr;
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [SW-1:0]          req_slot;
  logic                   done_valid;
  logic [SW-1:0]          done_slot;
  logic                   retire_valid;
  logic [INDEX_WIDTH-1:0] retire_trace_index;
  logic [ADDR_WIDTH-1:0]  retire_mem_addr;
  logic [OW-1:0]          occupancy;
  logic                   dedup_hit;

  modport slave (
    input  in_valid, in_trace_index, in_mem_addr,
    input  req_ready, done_valid, done_slot,
    output in_ready, req_valid, req_addr, req_slot,
    output retire_valid, retire_trace_index,
    output retire_mem_addr, occupancy, dedup_hit
  );

  modport master (
    output in_valid, in_trace_index, in_mem_addr,
    output req_ready, done_valid, done_slot,
    input  in_ready, req_valid, req_addr, req_slot,
    input  retire_valid, retire_trace_index,
    input  retire_mem_addr, occupancy, dedup_hit
  );
endinterface

// File: rtl/nway_trace_request_tracker.sv
// Trace-entry tracker: slots issue prefetches and retire on done.
// Optional duplicate-address drop: NWAY_TRACKER_DEDUP_EN.
module nway_trace_request_tracker #(
  parameter int TRACKER_SLOTS = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int INDEX_WIDTH   = 4
) (
  input logic clk,
  input logic rst,
  nway_trace_request_tracker_if.slave bus
);
  localparam int SW =
    (TRACKER_SLOTS > 1) ? $clog2(TRACKER_SLOTS) : 1;
  localparam int OW = $clog2(TRACKER_SLOTS + 1);

  typedef struct packed {
    logic                   occupied;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic                   processing;
    logic [INDEX_WIDTH-1:0] trace_index;
  } cache_tracker_t;

  cache_tracker_t slots_q [TRACKER_SLOTS];
  cache_tracker_t slots_n [TRACKER_SLOTS];

  logic                   free_any;
  logic [SW-1:0]          free_idx;
  logic                   mk_any;
  logic [SW-1:0]          mk_idx;
  logic                   dup_hit;
  logic                   done_hit;
  cache_tracker_t         done_ent;
  logic                   accept;
  logic                   alloc;
  logic                   issue_load;
  logic [OW-1:0]          occ_n;

  logic                   req_valid_q;
  logic [ADDR_WIDTH-1:0]  req_addr_q;
  logic [SW-1:0]          req_slot_q;
  logic                   ret_valid_q;
  logic [INDEX_WIDTH-1:0] ret_index_q;
  logic [ADDR_WIDTH-1:0]  ret_addr_q;
  logic [OW-1:0]          occ_q;

  // Priority pick of free / make-request slots, done lookup
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    mk_any   = 1'b0;
    mk_idx   = '0;
    dup_hit  = 1'b0;
    done_hit = 1'b0;
    done_ent = '0;
    for (int i = TRACKER_SLOTS - 1; i >= 0; i--) begin
      if (!slots_q[i].occupied) begin
        free_any = 1'b1;
        free_idx = SW'(i);
      end
      if (slots_q[i].occupied && !slots_q[i].processing) begin
        mk_any = 1'b1;
        mk_idx = SW'(i);
      end
`ifdef NWAY_TRACKER_DEDUP_EN
      if (slots_q[i].occupied &&
          slots_q[i].mem_addr == bus.in_mem_addr)
        dup_hit = 1'b1;
`endif
      if (bus.done_valid && bus.done_slot == SW'(i) &&
          slots_q[i].occupied && slots_q[i].processing) begin
        done_hit = 1'b1;
        done_ent = slots_q[i];
      end
    end
  end

  assign bus.in_ready = free_any | dup_hit;
  assign accept       = bus.in_valid & bus.in_ready;
  assign alloc        = accept & ~dup_hit;
  assign issue_load   = ~req_valid_q | bus.req_ready;

  // Next slot state: allocate, mark issued, free on done
  always_comb begin
    for (int i = 0; i < TRACKER_SLOTS; i++)
      slots_n[i] = slots_q[i];
    if (alloc) begin
      slots_n[free_idx].occupied    = 1'b1;
      slots_n[free_idx].processing  = 1'b0;
      slots_n[free_idx].mem_addr    = bus.in_mem_addr;
      slots_n[free_idx].trace_index = bus.in_trace_index;
    end
    if (issue_load && mk_any)
      slots_n[mk_idx].processing = 1'b1;
    for (int i = 0; i < TRACKER_SLOTS; i++)
      if (done_hit && bus.done_slot == SW'(i)) begin
        slots_n[i].occupied   = 1'b0;
        slots_n[i].processing = 1'b0;
      end
    occ_n = '0;
    for (int i = 0; i < TRACKER_SLOTS; i++)
      occ_n = occ_n + OW'(slots_n[i].occupied);
  end

  // Slot storage and registered occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TRACKER_SLOTS; i++)
        slots_q[i] <= '0;
      occ_q <= '0;
    end else begin
      for (int i = 0; i < TRACKER_SLOTS; i++)
        slots_q[i] <= slots_n[i];
      occ_q <= occ_n;
    end
  end

  // One-entry request register, held while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_slot_q  <= '0;
    end else if (issue_load) begin
      req_valid_q <= mk_any;
      if (mk_any) begin
        req_addr_q <= slots_q[mk_idx].mem_addr;
        req_slot_q <= mk_idx;
      end
    end
  end

  // Retire pulse carries the freed slot's entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_valid_q <= 1'b0;
      ret_index_q <= '0;
      ret_addr_q  <= '0;
    end else begin
      ret_valid_q <= done_hit;
      if (done_hit) begin
        ret_index_q <= done_ent.trace_index;
        ret_addr_q  <= done_ent.mem_addr;
      end
    end
  end

`ifdef NWAY_TRACKER_DEDUP_EN
  logic dedup_q;

  // Duplicate drop pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dedup_q <= 1'b0;
    else     dedup_q <= accept & dup_hit;
  end

  assign bus.dedup_hit = dedup_q;
`else
  assign bus.dedup_hit = 1'b0;
`endif

  assign bus.req_valid          = req_valid_q;
  assign bus.req_addr           = req_addr_q;
  assign bus.req_slot           = req_slot_q;
  assign bus.retire_valid       = ret_valid_q;
  assign bus.retire_trace_index = ret_index_q;
  assign bus.retire_mem_addr    = ret_addr_q;
  assign bus.occupancy          = occ_q;
endmodule
